hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

- Pipeline hazard and forwarding controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Tracks the destination register of every in-flight instruction and produces the registered `SEL_A`/`SEL_B` selects consumed by the EX-stage operand muxes: 00 register file, 01 WB value, 10 EX/MEM ALU value.
- Detects load-use hazards, stalls IF/ID for one cycle and inserts an EX bubble.
- Applies branch flushes and keeps saturating performance counters.

## Interface
Parameters:
- `REG_W`, 5: register index width.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: the block's single clock; everything is registered on its rising edge.
- `reset` in 1: synchronous, active-high.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rs1`, `id_rs2` in REG_W: source register indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2` in 1: the ID instruction reads that source.
- `id_rd` in REG_W: destination of the ID instruction.
- `id_regwrite` in 1: the ID instruction writes `id_rd`.
- `id_memread` in 1: the ID instruction is a load.
- `flush` in 1: taken branch or jump resolved in EX; kills the ID instruction.
- `SEL_A`, `SEL_B` out 2: registered operand selects for the instruction now in EX.
- `stall` out 1: combinational; hold PC and IF/ID this cycle.
- `fwd_count` out CNT_W: saturating count of EX cycles with any select ≠ 00.
- `stall_count` out CNT_W: saturating count of load-use stall cycles.

## Operation
- The block keeps three shadow entries mirroring the pipeline: `ex`, `mem`, `wb`. Each entry holds `{valid, rd, regwrite, memread}`.
- Every cycle the entries advance: `wb←mem`, `mem←ex`, `ex←ID info`. There is no external pipeline hold input.
- An entry is a forwarding producer only when `valid & regwrite & rd≠0`.

Select computation, made in ID for each used source `s` and registered into `SEL_*` at the edge:
- If entry `ex` is a producer with `rd==s`, select 10. That instruction will be in MEM when the consumer is in EX.
- Otherwise, if entry `mem` is a producer with `rd==s`, select 01. That instruction will be in WB.
- Otherwise select 00.
- Youngest producer wins: 10 has priority over 01.
- An unused source, `s==0`, or `id_valid=0` gives 00.
- The current `wb` producer never forwards. The register file writes before it reads in the same cycle, so the register path is already correct.

Load-use hazard:
- `stall = id_valid & ~flush & ex.valid & ex.memread & ex.rd≠0 & ((id_use_rs1 & id_rs1==ex.rd) | (id_use_rs2 & id_rs2==ex.rd))`.
- On a stall, entry `ex` loads a bubble (valid=0), `SEL_A`/`SEL_B` load 00, and the ID inputs are re-presented next cycle.
- On the re-presented cycle the load is in `mem`, so the consumer gets select 01.

Flush:
- `flush` makes entry `ex` load a bubble and the selects load 00.
- `flush` overrides `stall`: `stall` is 0 while `flush` is 1.

Counters:
- `fwd_count` increments at an edge when the registered selects are non-zero.
- `stall_count` increments at an edge when `stall` is 1.
- Both saturate at all-ones and never wrap.

## Timing
- Reset values: all entries invalid; `SEL_A=SEL_B=00`; `stall=0`; both counters 0.
- A `reset` asserted mid-stall takes effect at the next edge. `stall` drops in that same cycle's combinational path once the entries clear (the entries are invalid after the edge).
- Select latency: ID inputs at cycle N produce `SEL_*` valid for the whole of cycle N+1 (the EX cycle).
- `stall` is combinational from the ID inputs and entry `ex`, with no added latency. A load-use pair costs exactly 1 bubble.
- If one instruction is a producer in both `ex` and `mem` for the same rd (back-to-back writes to one register), the `ex` producer is selected (10).
- `id_rd` is captured into `ex` even when `id_regwrite=0`. It is ignored because of the regwrite gating.

## Structure
- Shared package `core_pkg`:
  - constants `SEL_REG=2'b00`, `SEL_WB=2'b01`, `SEL_ALU=2'b10`;
  - typedef `stage_info_t {valid, rd, regwrite, memread}`.
- Sub-module `fwd_src_match`: combinational. Takes one source index, its use bit and the `ex`/`mem` entries; outputs a 2-bit select and a load-hit flag. Instantiated twice (rs1, rs2).
- The top level holds the entries, the select registers, the stall/flush logic and the counters.

## Test plan
- Back-to-back RAW: `add x5,x1,x2` then `add x6,x5,x3` → second instruction's EX cycle shows `SEL_A=10`, `SEL_B=00`, `stall=0`.
- Distance-2 RAW: producer writes x7, one independent instruction, then a consumer reading x7 on rs2 → `SEL_B=01`; with two intervening instructions → `SEL_B=00`.
- Load-use: `lw x8` then `add x9,x8,x8` → `stall=1` for exactly 1 cycle, EX bubble with selects 00, then `SEL_A=SEL_B=01`; `stall_count=1`.
- x0 and priority: producer to x0 then reader of x0 → 00. Two consecutive writes to x4 then a reader → 10.
- Flush: a load in EX and a dependent instruction in ID with `flush=1` → `stall=0`, next selects 00, entry `ex` invalid, `stall_count` unchanged.
- Reset/saturation: `reset` during a stall → all outputs 0 at the next cycle. Force `fwd_count` to 0xFFFF then forward again → stays 0xFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the pipeline hazard/forwarding controller.
//
// Contents:
//   RD_W          register index width carried in a shadow pipeline entry
//   SEL_REG       operand select: register file value
//   SEL_WB        operand select: WB-stage value
//   SEL_ALU       operand select: EX/MEM ALU value
//   stage_info_t  one shadow pipeline entry {valid, rd, regwrite, memread}
//   is_producer   true when an entry can forward a result
package core_pkg;

    localparam int RD_W = 5;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } stage_info_t;

    // x0 is hardwired to zero, so a write to it never produces a usable value.
    function automatic logic is_producer(stage_info_t e);
        return e.valid & e.regwrite & (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: combinational forwarding/hazard match for one source operand.
//
// Ports:
//   src       in  REG_W  source register index of the ID instruction
//   use_src   in  1      the ID instruction actually reads src
//   ex_info   in  entry  shadow entry for the instruction now in EX
//   mem_info  in  entry  shadow entry for the instruction now in MEM
//   sel       out 2      operand select (SEL_REG / SEL_WB / SEL_ALU)
//   load_hit  out 1      src depends on a load currently in EX
module fwd_src_match
    import core_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  stage_info_t      ex_info,
    input  stage_info_t      mem_info,
    output logic [1:0]       sel,
    output logic             load_hit
);

    logic live_src;

    // A source that is not read, or is x0, never needs a bypass.
    assign live_src = use_src & (src != '0);

    always_comb begin
        sel = SEL_REG;
        // EX is younger than MEM, so checking it first gives it priority.
        if (live_src && is_producer(ex_info) && (src == ex_info.rd)) begin
            sel = SEL_ALU;
        end else if (live_src && is_producer(mem_info) && (src == mem_info.rd)) begin
            sel = SEL_WB;
        end
    end

    // Load data is not available until the end of MEM, so a consumer directly
    // behind a load cannot be served by the EX/MEM bypass.
    assign load_hit = use_src & ex_info.valid & ex_info.memread &
                      (ex_info.rd != '0) & (src == ex_info.rd);

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: hazard and forwarding controller for a 5-stage RV32 core.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   id_valid                   ID stage holds a real instruction
//   id_rs1, id_rs2             source indices of the ID instruction
//   id_use_rs1, id_use_rs2     the ID instruction reads that source
//   id_rd, id_regwrite         destination and write-enable of the ID instruction
//   id_memread                 the ID instruction is a load
//   flush                      taken branch/jump resolved in EX; kills ID
//   SEL_A, SEL_B               registered operand selects for the EX instruction
//   stall                      combinational: hold PC and IF/ID this cycle
//   fwd_count                  saturating count of EX cycles with a bypass
//   stall_count                saturating count of load-use stall cycles
//
// The block mirrors the pipeline with three shadow entries (ex, mem, wb) that
// advance every cycle. Selects are computed from the ID inputs against the ex
// and mem entries and registered so they line up with the consumer's EX cycle.
// The wb entry never forwards: the register file writes before it reads.
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       SEL_A,
    output logic [1:0]       SEL_B,
    output logic             stall,
    output logic [CNT_W-1:0] fwd_count,
    output logic [CNT_W-1:0] stall_count
);

    generate
        if (REG_W != RD_W) begin : g_bad_reg_w
            $error("hazard_fwd_unit: REG_W must equal core_pkg::RD_W");
        end
    endgenerate

    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    stage_info_t ex_d;

    logic [1:0] sel_a_raw;
    logic [1:0] sel_b_raw;
    logic       hit_a;
    logic       hit_b;
    logic       kill_id;
    logic [1:0] sel_a_d;
    logic [1:0] sel_b_d;

    fwd_src_match #(.REG_W(REG_W)) u_match_rs1 (
        .src      (id_rs1),
        .use_src  (id_use_rs1),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .sel      (sel_a_raw),
        .load_hit (hit_a)
    );

    fwd_src_match #(.REG_W(REG_W)) u_match_rs2 (
        .src      (id_rs2),
        .use_src  (id_use_rs2),
        .ex_info  (ex_q),
        .mem_info (mem_q),
        .sel      (sel_b_raw),
        .load_hit (hit_b)
    );

    // Flush takes precedence: a killed instruction cannot cause a stall.
    assign stall   = id_valid & ~flush & (hit_a | hit_b);
    assign kill_id = flush | stall;

    always_comb begin
        ex_d    = '0;
        sel_a_d = SEL_REG;
        sel_b_d = SEL_REG;
        if (!kill_id && id_valid) begin
            // rd is captured even without regwrite; is_producer gates it later.
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            sel_a_d       = sel_a_raw;
            sel_b_d       = sel_b_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            SEL_A <= SEL_REG;
            SEL_B <= SEL_REG;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            SEL_A <= sel_a_d;
            SEL_B <= sel_b_d;
        end
    end

    // Counters sample the selects currently presented to EX and the live stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (((SEL_A != SEL_REG) || (SEL_B != SEL_REG)) && (fwd_count != '1)) begin
                fwd_count <= fwd_count + 1'b1;
            end
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
